// File: rtl/uart_alu_pkg.sv
// Shared constants for the UART/ALU frame sequencer: opcodes, error byte,
// FSM state encoding and the opcode legality check.
package uart_alu_pkg;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

  localparam logic [7:0] ERR_CODE = 8'hEE;

  typedef logic [2:0] state_t;
  localparam state_t ST_RX_A  = 3'd0;
  localparam state_t ST_RX_B  = 3'd1;
  localparam state_t ST_RX_OP = 3'd2;
  localparam state_t ST_EXEC  = 3'd3;
  localparam state_t ST_TX    = 3'd4;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_legal_op = 1'b1;
      default:                        is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_alu_sequencer_frame_timer.sv
// Inter-byte timeout counter: clear has priority over enable, expired flags
// the last allowed waiting cycle.
module frame_timer #(
  parameter int TIMEOUT = 1000000,
  parameter int TO_BIT  = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_BIT-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count <= '0;
    else if (clr)  count <= '0;
    else if (en)   count <= count + TO_BIT'(1);
  end

  assign expired = (count == TO_BIT'(TIMEOUT - 1));

endmodule

// File: rtl/uart_alu_sequencer.sv
// Pops an A/B/opcode frame from the UART RX FIFO, drives the external ALU and
// pushes one result (or ERR_CODE for illegal opcodes) into the TX FIFO.
//
// state    | meaning
// RX_A     | idle, waiting for operand A (timer held clear)
// RX_B     | waiting for operand B, timeout armed
// RX_OP    | waiting for opcode, timeout armed
// EXEC     | one cycle: capture ALU result or error byte
// TX       | waiting for room in TX FIFO, then push
module uart_alu_sequencer
  import uart_alu_pkg::*;
#(
  parameter int N_BIT   = 8,
  parameter int N_OP    = 6,
  parameter int TIMEOUT = 1000000,
  parameter int TO_BIT  = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_empty,
  input  logic [N_BIT-1:0] r_data,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic             wr_uart,
  output logic [N_BIT-1:0] w_data,
  output logic [N_BIT-1:0] alu_a,
  output logic [N_BIT-1:0] alu_b,
  output logic [N_OP-1:0]  alu_op,
  input  logic [N_BIT-1:0] alu_result,
  output logic             busy,
  output logic             err_op,
  output logic             timeout
);

  state_t state, state_nxt;
  logic   run_q;
  logic   expired;
  logic   op_legal;
  logic   timer_clr, timer_en;

  // run_q keeps the combinational pop strobe quiet during and right after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RX_A;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RX_A:  if (rd_uart) state_nxt = ST_RX_B;
      ST_RX_B:  if (rd_uart) state_nxt = ST_RX_OP;
                else if (timeout) state_nxt = ST_RX_A;
      ST_RX_OP: if (rd_uart) state_nxt = ST_EXEC;
                else if (timeout) state_nxt = ST_RX_A;
      ST_EXEC:  state_nxt = ST_TX;
      ST_TX:    if (wr_uart) state_nxt = ST_RX_A;
      default:  state_nxt = ST_RX_A;
    endcase
  end

  assign op_legal = is_legal_op(alu_op);

  always_comb begin
    rd_uart = 1'b0;
    wr_uart = 1'b0;
    err_op  = 1'b0;
    timeout = 1'b0;
    busy    = (state != ST_RX_A);
    case (state)
      ST_RX_A:  rd_uart = run_q & ~rx_empty;
      ST_RX_B,
      ST_RX_OP: begin
        rd_uart = run_q & ~rx_empty;
        timeout = expired & rx_empty;
      end
      ST_EXEC:  err_op  = ~op_legal;
      ST_TX:    wr_uart = ~tx_full;
      default:  ;
    endcase
  end

  assign timer_en  = ((state == ST_RX_B) || (state == ST_RX_OP)) && rx_empty;
  assign timer_clr = rd_uart || timeout || (state == ST_RX_A);

  frame_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_BIT  (TO_BIT)
  ) u_frame_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      w_data <= '0;
    end else begin
      if (rd_uart && state == ST_RX_A)  alu_a  <= r_data;
      if (rd_uart && state == ST_RX_B)  alu_b  <= r_data;
      if (rd_uart && state == ST_RX_OP) alu_op <= r_data[N_OP-1:0];
      if (state == ST_EXEC)             w_data <= op_legal ? alu_result : N_BIT'(ERR_CODE);
    end
  end

endmodule

// File: doc/uart_alu_sequencer.md
# uart_alu_sequencer

Frame controller between the UART block's FIFO-side interface and an external combinational ALU. It pops a three-byte command frame from the receive FIFO in the order operand A, operand B, opcode. It then drives the ALU, captures the result and pushes one result byte into the transmit FIFO. An inter-byte timeout discards incomplete frames, and an illegal opcode returns a fixed error byte instead of a result.

## Interface
- N_BIT, 8: data/operand width.
- N_OP, 6: opcode width; opcode taken from r_data[N_OP-1:0], upper bits ignored.
- TIMEOUT, 1000000: max cycles waiting for byte B or opcode before the frame is dropped.
- TO_BIT, 20: timeout counter width; must satisfy 2^TO_BIT > TIMEOUT.
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- rx_empty  in  1  UART receive FIFO empty.
- r_data  in  N_BIT  receive FIFO head, valid whenever rx_empty=0.
- rd_uart  out  1  receive FIFO pop strobe.
- tx_full  in  1  UART transmit FIFO full.
- wr_uart  out  1  transmit FIFO push strobe.
- w_data  out  N_BIT  result byte to transmit FIFO.
- alu_a, alu_b  out  N_BIT  registered operands to ALU.
- alu_op  out  N_OP  registered opcode to ALU.
- alu_result  in  N_BIT  combinational ALU output.
- busy  out  1  high whenever state != RX_A.
- err_op  out  1  one-cycle pulse: illegal opcode received.
- timeout  out  1  one-cycle pulse: frame dropped on timeout.

## Operation
- States: RX_A, RX_B, RX_OP, EXEC, TX. Reset state is RX_A.
- RX_A, RX_B, RX_OP:
  - rd_uart = ~rx_empty (combinational from state and rx_empty).
  - On a cycle with rd_uart=1, the clock edge loads r_data into alu_a, alu_b or alu_op respectively and advances the state.
- Legal opcodes: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SRA 0x03, SRL 0x02. Any other value is illegal.
- EXEC (exactly one cycle):
  - Legal opcode: w_data <= alu_result.
  - Illegal opcode: w_data <= ERR_CODE (0xEE) and err_op pulses high during EXEC. alu_result is ignored.
  - Next state is TX.
- TX:
  - wr_uart = ~tx_full.
  - On an edge with wr_uart=1, go to RX_A.
  - No timeout applies in TX; the block waits on tx_full indefinitely.
- Timeout counter:
  - Cleared on every pop and on entry to RX_A.
  - Increments each cycle in RX_B or RX_OP while rx_empty=1.
  - When it reaches TIMEOUT-1 with rx_empty still 1: next state RX_A, timeout pulses that cycle, and no byte is written.
  - A byte arriving in that same cycle is popped and the timeout is suppressed: the pop wins.
- The counter never runs in RX_A, so an idle link never times out.
- Arithmetic belongs to the external ALU. The block performs no width extension; results are N_BIT, wrapping modulo 2^N_BIT.
- Reset mid-frame: all registers return to reset values and the partial frame is lost. No strobe is emitted in the cycle reset is released.

## Timing
- Reset values: rd_uart, wr_uart, busy, err_op and timeout are 0. w_data, alu_a, alu_b and alu_op are 0.
- Pop latency: rd_uart asserts in the same cycle rx_empty falls while in an RX state.
  - Back-to-back pops are allowed: three queued bytes are consumed in 3 consecutive cycles.
- Result latency: the rd_uart for the opcode is in cycle t, EXEC is t+1, and wr_uart is at t+2 if tx_full=0.
- Strobes:
  - rd_uart and wr_uart are never high together.
  - Each strobe is high for exactly one cycle per byte.
- w_data is stable from EXEC's edge until the push edge.
- alu_a, alu_b and alu_op hold their values until overwritten by the next frame.

## Structure
- Package uart_alu_pkg holds:
  - opcode constants (OP_ADD through OP_SRL);
  - ERR_CODE;
  - the state encoding (3-bit localparams);
  - a function is_legal_op.
- One natural sub-module, frame_timer: the TO_BIT-bit timeout counter with clear, enable and an expired output.
- The FSM stays in the top module. The ALU and the UART are instantiated by the parent, not here.

## Test plan
- Frame 0x05, 0x03, 0x20, bench ALU model connected -> exactly three rd_uart pulses, then w_data=0x08 with one wr_uart pulse 2 cycles after the third pop; busy falls after it.
- Frame 0x03, 0x05, 0x22 -> w_data=0xFE (wrap).
- Frame 0x12, 0x34, 0x3F -> err_op pulse in EXEC, w_data=0xEE, alu_result ignored (bench drives 0x55).
- tx_full held at 1 for 10 cycles while in TX -> wr_uart stays 0 and w_data is stable; when tx_full drops, a single wr_uart pulse, then state RX_A.
- TIMEOUT=16, send only byte 0x07 -> timeout pulse 16 cycles after the pop, no wr_uart. Then frame 0x01, 0x01, 0x20 -> w_data=0x02.
- Assert RESET while in RX_OP -> all outputs 0 asynchronously. After release, frame 0xF0, 0x0F, 0x25 -> w_data=0xFF.
